mont_mult_serial: RTL and testbench

- Radix-2, bit-serial Montgomery multiplier. Computes result = A·B·2^(-N) mod M.
- It is the arithmetic engine that each exponentiation core instantiates. The core issues one multiply per square/multiply step, and the RSA wrapper's two cores each own one instance.
- Operands are latched on start. The block iterates one multiplier bit per cycle, performs one conditional final subtraction, and signals done.

---
 rtl/mont_pkg.sv | 18 +
 rtl/mont_mult_serial_if.sv | 26 ++
 rtl/mont_step.sv | 22 ++
 rtl/mont_mult_serial.sv | 104 ++++++++++
 tb/tb_mont_mult_serial.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mont_pkg.sv
// Shared definitions for the serial Montgomery multiplier: default width and FSM state encoding.
package mont_pkg;

  localparam int unsigned MONT_N = 512;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOOP = 2'd1;
  localparam logic [1:0] ST_SUB  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StLoop = ST_LOOP,
    StSub  = ST_SUB,
    StDone = ST_DONE
  } mont_state_e;

endpackage

// File: rtl/mont_mult_serial_if.sv
// Request/response bundle between an exponentiation core (master) and its multiplier (slave).
interface mont_mult_serial_if
  import mont_pkg::*;
#(
  parameter int unsigned N = MONT_N
);

  logic         start;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic [N-1:0] in_m;
  logic         busy;
  logic         done;
  logic [N-1:0] result;

  modport master (
    output start, in_a, in_b, in_m,
    input  busy, done, result
  );

  modport slave (
    input  start, in_a, in_b, in_m,
    output busy, done, result
  );

endinterface

// File: rtl/mont_step.sv
// One radix-2 Montgomery iteration: C' = (C + a_bit*B [+ M if odd]) / 2, carried at full width.
module mont_step #(
  parameter int unsigned N = 8
) (
  input  logic [N+1:0] c_i,
  input  logic         a_bit_i,
  input  logic [N-1:0] b_i,
  input  logic [N-1:0] m_i,
  output logic [N+1:0] c_o
);

  logic [N+2:0] sum;
  logic [N+2:0] t;

  // One spare bit above C so out-of-contract operands still never lose a carry before the shift.
  always_comb begin
    sum = {1'b0, c_i} + (a_bit_i ? {3'b000, b_i} : '0);
    t   = sum[0] ? sum + {3'b000, m_i} : sum;
    c_o = (N+2)'(t >> 1);
  end

endmodule

// File: rtl/mont_mult_serial.sv
// Bit-serial radix-2 Montgomery multiplier: result = A*B*2^(-N) mod M in N+2 cycles.
module mont_mult_serial
  import mont_pkg::*;
#(
  parameter int unsigned N     = MONT_N,
  parameter int unsigned CNT_W = $clog2(N)
) (
  input logic               clk,
  input logic               resetn,
  mont_mult_serial_if.slave bus
);

  mont_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     a_q, a_d;
  logic [N-1:0]     b_q, b_d;
  logic [N-1:0]     m_q, m_d;
  logic [N+1:0]     c_q, c_d;
  logic [N-1:0]     result_q, result_d;

  logic [N+1:0]     c_step;
  logic [N-1:0]     c_minus_m;
  logic             c_ge_m;

  mont_step #(
    .N (N)
  ) u_step (
    .c_i     (c_q),
    .a_bit_i (a_q[cnt_q]),
    .b_i     (b_q),
    .m_i     (m_q),
    .c_o     (c_step)
  );

  // Only the low N bits of the difference matter: when C >= M the result is below M.
  assign c_ge_m    = (c_q >= {2'b00, m_q});
  assign c_minus_m = c_q[N-1:0] - m_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    m_d      = m_q;
    c_d      = c_q;
    result_d = result_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          m_d     = bus.in_m;
          c_d     = '0;
          cnt_d   = '0;
          state_d = StLoop;
        end
      end
      StLoop: begin
        c_d = c_step;
        if (cnt_q == CNT_W'(N - 1)) begin
          state_d = StSub;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StSub: begin
        result_d = c_ge_m ? c_minus_m : c_q[N-1:0];
        state_d  = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      c_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      m_q      <= m_d;
      c_q      <= c_d;
      result_q <= result_d;
    end
  end

  assign bus.busy   = (state_q != StIdle);
  assign bus.done   = (state_q == StDone);
  assign bus.result = result_q;

endmodule

// File: tb/tb_mont_mult_serial.sv
// Directed and randomized checks of mont_mult_serial at N=8 and N=512 against modular arithmetic.
module tb_mont_mult_serial;

  typedef logic [1039:0] wide_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  always #5 clk = ~clk;

  mont_mult_serial_if #(.N(8))   bus8 ();
  mont_mult_serial_if #(.N(512)) bus512 ();

  mont_mult_serial #(.N(8)) dut8 (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus8)
  );

  mont_mult_serial #(.N(512)) dut512 (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus512)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // Reference: r = (A*B mod M) * (2^-1 mod M)^n mod M, with 2^-1 = (M+1)/2 for odd M.
  function automatic wide_t mont_ref(input wide_t a, input wide_t b, input wide_t m, input int n);
    wide_t base, rinv;
    int    e;
    base = (m + 1) >> 1;
    rinv = 1;
    e    = n;
    while (e > 0) begin
      if (e[0]) rinv = (rinv * base) % m;
      base = (base * base) % m;
      e    = e >> 1;
    end
    return (((a * b) % m) * rinv) % m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input wide_t obs, input wide_t exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs[511:0], exp[511:0]);
    end
  endtask

  task automatic set_inputs(input bit big, input wide_t a, input wide_t b, input wide_t m);
    if (big) begin
      bus512.in_a = a[511:0];
      bus512.in_b = b[511:0];
      bus512.in_m = m[511:0];
    end else begin
      bus8.in_a = a[7:0];
      bus8.in_b = b[7:0];
      bus8.in_m = m[7:0];
    end
  endtask

  task automatic set_start(input bit big, input logic v);
    if (big) bus512.start = v;
    else     bus8.start = v;
  endtask

  function automatic logic get_done(input bit big);
    return big ? bus512.done : bus8.done;
  endfunction

  function automatic wide_t get_result(input bit big);
    return big ? wide_t'(bus512.result) : wide_t'(bus8.result);
  endfunction

  // Pulses start for one edge; lat is the cycle index (start edge = 0) in which done is seen.
  task automatic run_op(input bit big, input wide_t a, input wide_t b, input wide_t m,
                        output wide_t res, output int lat);
    int n;
    n = big ? 512 : 8;
    set_inputs(big, a, b, m);
    set_start(big, 1'b1);
    tick();
    set_start(big, 1'b0);
    lat = 1;
    while (!get_done(big) && lat < n + 10) begin
      tick();
      lat++;
    end
    res = get_result(big);
    tick();
  endtask

  task automatic op_check(input string tag, input bit big, input wide_t a, input wide_t b,
                          input wide_t m);
    wide_t res;
    int    lat;
    int    n;
    n = big ? 512 : 8;
    run_op(big, a, b, m, res, lat);
    check({tag, " result"}, res, mont_ref(a, b, m, n));
    check({tag, " below M"}, wide_t'(res < m), wide_t'(1));
    check({tag, " latency"}, wide_t'(lat), wide_t'(n + 2));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    wide_t res, res_hold, m, a, b;
    int    lat, t, n_done;
    int    dt[$];
    wide_t dr[$];

    bus8.start   = 1'b0;
    bus512.start = 1'b0;
    set_inputs(1'b0, 0, 0, 13);
    set_inputs(1'b1, 0, 0, 13);

    resetn = 1'b0;
    repeat (3) tick();
    check("reset busy8", wide_t'(bus8.busy), 0);
    check("reset done8", wide_t'(bus8.done), 0);
    check("reset result8", wide_t'(bus8.result), 0);
    check("reset busy512", wide_t'(bus512.busy), 0);
    check("reset result512", wide_t'(bus512.result), 0);
    resetn = 1'b1;
    tick();

    // Directed test-plan cases, N=8, M=13
    set_inputs(1'b0, 5, 7, 13);
    set_start(1'b0, 1'b1);
    tick();
    set_start(1'b0, 1'b0);
    check("busy after start", wide_t'(bus8.busy), 1);
    lat = 1;
    while (!bus8.done && lat < 20) begin
      tick();
      lat++;
    end
    check("A5B7 latency", wide_t'(lat), 10);
    check("A5B7 result", wide_t'(bus8.result), 1);
    tick();
    check("busy after done", wide_t'(bus8.busy), 0);

    run_op(1'b0, 9, 5, 13, res, lat);
    check("A9B5 result", res, 5);
    run_op(1'b0, 12, 12, 13, res, lat);
    check("A12B12 result", res, 3);
    run_op(1'b0, 0, 12, 13, res, lat);
    check("A0B12 result", res, 0);
    check("A0B12 latency", wide_t'(lat), 10);
    run_op(1'b0, 12, 0, 13, res, lat);
    check("A12B0 result", res, 0);
    check("A12B0 latency", wide_t'(lat), 10);

    // Result must hold across idle cycles even while inputs move
    res_hold = get_result(1'b0);
    set_inputs(1'b0, 3, 4, 11);
    repeat (5) tick();
    check("result stable idle", wide_t'(bus8.result), res_hold);

    // start held high: back-to-back ops, A changed mid-LOOP of the fifth
    set_inputs(1'b0, 5, 7, 13);
    set_start(1'b0, 1'b1);
    t = 0;
    while (dt.size() < 6 && t < 120) begin
      tick();
      t++;
      if (t == 48) set_inputs(1'b0, 12, 7, 13);
      if (bus8.done) begin
        dt.push_back(t);
        dr.push_back(wide_t'(bus8.result));
        if (dt.size() == 6) set_start(1'b0, 1'b0);
      end
    end
    set_start(1'b0, 1'b0);
    tick();
    check("held done count", wide_t'(dt.size()), 6);
    if (dt.size() > 0) check("held first done", wide_t'(dt[0]), 10);
    for (int i = 1; i < dt.size(); i++) check("held spacing", wide_t'(dt[i] - dt[i-1]), 11);
    for (int i = 0; i < dr.size(); i++) begin
      check("held result", dr[i], (i < 5) ? mont_ref(5, 7, 13, 8) : mont_ref(12, 7, 13, 8));
    end

    // Reset during LOOP iteration 4 aborts with no done
    set_inputs(1'b0, 5, 7, 13);
    set_start(1'b0, 1'b1);
    tick();
    set_start(1'b0, 1'b0);
    repeat (4) tick();
    resetn = 1'b0;
    tick();
    check("abort busy", wide_t'(bus8.busy), 0);
    check("abort result", wide_t'(bus8.result), 0);
    check("abort done", wide_t'(bus8.done), 0);
    resetn = 1'b1;
    n_done = 0;
    repeat (15) begin
      tick();
      if (bus8.done) n_done++;
    end
    check("abort no done", wide_t'(n_done), 0);
    op_check("post-abort A5B7", 1'b0, 5, 7, 13);

    // Exhaustive A,B < 13 at N=8
    for (int ia = 0; ia < 13; ia++) begin
      for (int ib = 0; ib < 13; ib++) begin
        op_check("M13", 1'b0, wide_t'(ia), wide_t'(ib), 13);
      end
    end

    // M=255: corners plus random sample over A,B < M
    op_check("M255 corner", 1'b0, 254, 254, 255);
    op_check("M255 corner", 1'b0, 254, 1, 255);
    op_check("M255 corner", 1'b0, 0, 254, 255);
    for (int k = 0; k < 400; k++) begin
      op_check("M255 rand", 1'b0, wide_t'($urandom_range(254, 0)), wide_t'($urandom_range(254, 0)),
               255);
    end

    // N=512: random odd moduli with the top bit set
    for (int k = 0; k < 40; k++) begin
      m = '0;
      a = '0;
      b = '0;
      for (int w = 0; w < 16; w++) begin
        m[w*32 +: 32] = $urandom;
        a[w*32 +: 32] = $urandom;
        b[w*32 +: 32] = $urandom;
      end
      m[511] = 1'b1;
      m[0]   = 1'b1;
      a      = a % m;
      b      = (k == 0) ? 0 : b % m;
      op_check("N512 rand", 1'b1, a, b, m);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
